// File: rtl/encode_seq_cntl.sv
// Encode sequencer: per data line, pops one FIFO line, loads the engine, then
// walks the bitmatrix rows 0..M-1; each issued row is written out one cycle later.
module encode_seq_cntl #(
  parameter int M_MAX      = 128,
  parameter int M_MIN      = 2,
  parameter int LINE_CNT_W = 16,
  parameter int M_W        = $clog2(M_MAX+1)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  eng_rstn,
  input  logic                  start,
  input  logic [M_W-1:0]        MReg,
  input  logic [LINE_CNT_W-1:0] line_num_reg,
  input  logic                  inbuf_fifo_cntl_empty,
  input  logic                  outbuf_full,
  output logic                  cntl_inbuf_fifo_rd_rq,
  output logic                  cntl_inbuf_fifo_mem_en,
  output logic                  cntl_eng_load_line,
  output logic                  cntl_bm_mem_rd_en,
  output logic [M_W-1:0]        cntl_bm_mem_rd_addr,
  output logic                  cntl_outbuf_wr_en,
  output logic [M_W-1:0]        cntl_outbuf_row_idx,
  output logic                  busy,
  output logic                  done,
  output logic                  err_cfg
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_CALC  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]            state;
  logic [M_W-1:0]        m_lat;
  logic [M_W-1:0]        row_cnt;
  logic [LINE_CNT_W-1:0] lines_left;
  logic                  cfg_ok;
  logic                  issue;
  logic                  last_row;

  assign cfg_ok   = (MReg >= M_W'(M_MIN)) && (MReg <= M_W'(M_MAX)) &&
                    (line_num_reg != '0);
  assign issue    = (state == S_CALC) && !outbuf_full;
  assign last_row = (row_cnt == m_lat - M_W'(1));

  assign cntl_inbuf_fifo_rd_rq  = (state == S_FETCH) && !inbuf_fifo_cntl_empty;
  assign cntl_inbuf_fifo_mem_en = cntl_inbuf_fifo_rd_rq;
  assign cntl_eng_load_line     = (state == S_LOAD);
  assign cntl_bm_mem_rd_en      = issue;
  // Address is only meaningful in CALC; holds through outbuf_full stalls.
  assign cntl_bm_mem_rd_addr    = (state == S_CALC) ? row_cnt : '0;
  assign busy                   = (state != S_IDLE);
  assign done                   = (state == S_DONE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state               <= S_IDLE;
      m_lat               <= '0;
      row_cnt             <= '0;
      lines_left          <= '0;
      err_cfg             <= 1'b0;
      cntl_outbuf_wr_en   <= 1'b0;
      cntl_outbuf_row_idx <= '0;
    end else if (!eng_rstn) begin
      state               <= S_IDLE;
      m_lat               <= '0;
      row_cnt             <= '0;
      lines_left          <= '0;
      err_cfg             <= 1'b0;
      cntl_outbuf_wr_en   <= 1'b0;
      cntl_outbuf_row_idx <= '0;
    end else begin
      err_cfg             <= 1'b0;
      // One-stage delay matches the bitmatrix read latency.
      cntl_outbuf_wr_en   <= issue;
      cntl_outbuf_row_idx <= cntl_bm_mem_rd_addr;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (cfg_ok) begin
              m_lat      <= MReg;
              lines_left <= line_num_reg;
              state      <= S_FETCH;
            end else begin
              err_cfg <= 1'b1;
            end
          end
        end
        S_FETCH: if (!inbuf_fifo_cntl_empty) state <= S_LOAD;
        S_LOAD: begin
          row_cnt <= '0;
          state   <= S_CALC;
        end
        S_CALC: begin
          if (issue) begin
            if (last_row) begin
              row_cnt <= '0;
              if (lines_left != '0) lines_left <= lines_left - LINE_CNT_W'(1);
              state <= (lines_left == LINE_CNT_W'(1)) ? S_DONE : S_FETCH;
            end else begin
              row_cnt <= row_cnt + M_W'(1);
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_encode_seq_cntl.sv
// Directed bench for encode_seq_cntl: cycle-exact vector table plus
// hand sequences for FIFO/outbuf stalls, engine reset and start re-pulse.
module tb_encode_seq_cntl;
  localparam int M_W = 8;
  localparam int LW  = 16;

  logic          clk = 1'b0;
  logic          rstn, eng_rstn, start;
  logic [M_W-1:0] MReg;
  logic [LW-1:0]  line_num_reg;
  logic          empty, full;
  logic          rd_rq, mem_en, load, rd_en, wr_en, busy, done, err;
  logic [M_W-1:0] addr, row;

  encode_seq_cntl dut (
    .clk(clk), .rstn(rstn), .eng_rstn(eng_rstn), .start(start),
    .MReg(MReg), .line_num_reg(line_num_reg),
    .inbuf_fifo_cntl_empty(empty), .outbuf_full(full),
    .cntl_inbuf_fifo_rd_rq(rd_rq), .cntl_inbuf_fifo_mem_en(mem_en),
    .cntl_eng_load_line(load), .cntl_bm_mem_rd_en(rd_en),
    .cntl_bm_mem_rd_addr(addr), .cntl_outbuf_wr_en(wr_en),
    .cntl_outbuf_row_idx(row), .busy(busy), .done(done), .err_cfg(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic           start;
    logic [M_W-1:0] m;
    logic [LW-1:0]  lines;
    logic [7:0]     flags;  // {rd_rq,mem_en,load,rd_en,wr_en,busy,done,err}
    logic [M_W-1:0] addr;
    logic [M_W-1:0] row;
  } vec_t;

  int errors = 0;
  int checks = 0;
  int loads, wrs, dones, rqbad, popcalc, maxaddr;
  int rowsig;

  function automatic logic [23:0] obs();
    return {rd_rq, mem_en, load, rd_en, wr_en, busy, done, err, addr, row};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic mclr();
    loads = 0; wrs = 0; dones = 0; rqbad = 0; popcalc = 0; maxaddr = 0; rowsig = 0;
  endtask

  // Wait for the sample point of the current cycle and log observed events.
  task automatic smp();
    @(negedge clk);
    if (load) loads++;
    if (wr_en) begin wrs++; rowsig = (rowsig << 4) | int'(row[3:0]); end
    if (done) dones++;
    if (rd_rq && empty) rqbad++;
    if (rd_rq && rd_en) popcalc++;
    if (rd_en && int'(addr) > maxaddr) maxaddr = int'(addr);
  endtask

  task automatic nxt();
    @(posedge clk); #1;
  endtask

  vec_t tv[16];

  initial begin
    rstn = 1'b0; eng_rstn = 1'b1; start = 1'b0; MReg = '0; line_num_reg = '0;
    empty = 1'b0; full = 1'b0;
    mclr();

    // M=4, N=1 nominal run, then illegal configurations.
    tv[0]  = '{1'b1, 8'd4,   16'd1, 8'b0000_0000, 8'd0, 8'd0};
    tv[1]  = '{1'b0, 8'd4,   16'd1, 8'b1100_0100, 8'd0, 8'd0};
    tv[2]  = '{1'b0, 8'd4,   16'd1, 8'b0010_0100, 8'd0, 8'd0};
    tv[3]  = '{1'b0, 8'd4,   16'd1, 8'b0001_0100, 8'd0, 8'd0};
    tv[4]  = '{1'b0, 8'd4,   16'd1, 8'b0001_1100, 8'd1, 8'd0};
    tv[5]  = '{1'b0, 8'd4,   16'd1, 8'b0001_1100, 8'd2, 8'd1};
    tv[6]  = '{1'b0, 8'd4,   16'd1, 8'b0001_1100, 8'd3, 8'd2};
    tv[7]  = '{1'b0, 8'd4,   16'd1, 8'b0000_1110, 8'd0, 8'd3};
    tv[8]  = '{1'b0, 8'd4,   16'd1, 8'b0000_0000, 8'd0, 8'd0};
    tv[9]  = '{1'b1, 8'd1,   16'd1, 8'b0000_0000, 8'd0, 8'd0};
    tv[10] = '{1'b0, 8'd1,   16'd1, 8'b0000_0001, 8'd0, 8'd0};
    tv[11] = '{1'b1, 8'd129, 16'd1, 8'b0000_0000, 8'd0, 8'd0};
    tv[12] = '{1'b0, 8'd129, 16'd1, 8'b0000_0001, 8'd0, 8'd0};
    tv[13] = '{1'b1, 8'd4,   16'd0, 8'b0000_0000, 8'd0, 8'd0};
    tv[14] = '{1'b0, 8'd4,   16'd0, 8'b0000_0001, 8'd0, 8'd0};
    tv[15] = '{1'b0, 8'd4,   16'd0, 8'b0000_0000, 8'd0, 8'd0};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", int'(obs()), 0);
    rstn = 1'b1;
    nxt();

    for (int i = 0; i < 16; i++) begin
      start = tv[i].start; MReg = tv[i].m; line_num_reg = tv[i].lines;
      @(negedge clk);
      chk($sformatf("vec%0d", i), int'(obs()), int'({tv[i].flags, tv[i].addr, tv[i].row}));
      nxt();
    end
    start = 1'b0;

    // M=2, N=3, FIFO empty for 5 cycles at the second FETCH.
    mclr();
    for (int c = 0; c < 24; c++) begin
      start = (c == 0); MReg = 8'd2; line_num_reg = 16'd3;
      empty = (c >= 5 && c <= 9);
      smp();
      if (c == 5)  chk("fifo_stall_rq_low", int'(rd_rq), 0);
      if (c == 10) chk("fifo_resume_rq", int'(rd_rq), 1);
      if (c == 18) chk("fifo_done_cycle", int'(done), 1);
      nxt();
    end
    empty = 1'b0;
    chk("fifo_loads", loads, 3);
    chk("fifo_writes", wrs, 6);
    chk("fifo_rows", rowsig, 'h010101);
    chk("fifo_dones", dones, 1);
    chk("fifo_rq_while_empty", rqbad, 0);
    chk("fifo_pop_in_calc", popcalc, 0);

    // M=4, outbuf_full for 3 cycles after row 1 is issued.
    mclr();
    for (int c = 0; c < 14; c++) begin
      start = (c == 0); MReg = 8'd4; line_num_reg = 16'd1;
      full = (c >= 5 && c <= 7);
      smp();
      if (c == 5)  chk("full_row1_written", int'({wr_en, row}), 'h101);
      if (c == 6)  chk("full_stall", int'({rd_en, addr}), 'h002);
      if (c == 8)  chk("full_resume", int'({rd_en, addr}), 'h102);
      if (c == 10) chk("full_done_cycle", int'(done), 1);
      nxt();
    end
    full = 1'b0;
    chk("full_rows", rowsig, 'h0123);
    chk("full_writes", wrs, 4);

    // eng_rstn during CALC row 2 of M=8.
    mclr();
    for (int c = 0; c < 14; c++) begin
      start = (c == 0); MReg = 8'd8; line_num_reg = 16'd1;
      eng_rstn = (c != 5);
      smp();
      if (c == 5) chk("engrst_row2", int'({rd_en, addr}), 'h102);
      if (c == 6) chk("engrst_cleared", int'(obs()), 0);
      nxt();
    end
    eng_rstn = 1'b1;
    chk("engrst_no_done", dones, 0);
    chk("engrst_rows", rowsig, 'h01);
    mclr();
    for (int c = 0; c < 8; c++) begin
      start = (c == 0); MReg = 8'd2; line_num_reg = 16'd1;
      smp();
      if (c == 3) chk("engrst_restart_row0", int'({rd_en, addr}), 'h100);
      nxt();
    end
    chk("engrst_restart_rows", rowsig, 'h01);
    chk("engrst_restart_done", dones, 1);

    // start re-pulsed and MReg changed mid-run; latched M=2, N=2 must hold.
    mclr();
    for (int c = 0; c < 13; c++) begin
      start = (c == 0 || c == 3);
      MReg = (c == 0) ? 8'd2 : 8'd8;
      line_num_reg = (c == 0) ? 16'd2 : 16'd5;
      smp();
      if (c == 9)  chk("latch_done_cycle", int'(done), 1);
      if (c == 11) chk("latch_idle", int'(busy), 0);
      nxt();
    end
    start = 1'b0;
    chk("latch_rows", rowsig, 'h0101);
    chk("latch_maxaddr", maxaddr, 1);
    chk("latch_dones", dones, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/encode_seq_cntl.md
# encode_seq_cntl

Top-level encode sequencer for the EC accelerator. On a start command it latches M and the line count, then for each data line it fetches one line from the input-buffer FIFO, loads it into the engine, and steps the bitmatrix-memory row address through M compute cycles. It then writes each parity row to the output buffer and signals completion. It sits between the control registers and the input-buffer FIFO, bitmatrix memory, engine and output buffer, and replaces the free-running M-cycle counting previously done next to the input buffer.

## Interface
Parameters:
- M_MAX, 128, max parity rows
- M_MIN, 2, min parity rows
- LINE_CNT_W, 16, width of the line-count register
- M_W, $clog2(M_MAX+1), width of the M register and row counters

Ports:
- clk  in  1  single clock, all logic on rising edge
- rstn  in  1  asynchronous active-low reset
- eng_rstn  in  1  synchronous active-low engine reset
- start  in  1  one-cycle start pulse, sampled only in IDLE
- MReg  in  M_W  number of parity rows
- line_num_reg  in  LINE_CNT_W  number of data lines to encode
- inbuf_fifo_cntl_empty  in  1  input FIFO empty
- outbuf_full  in  1  output buffer cannot accept a row
- cntl_inbuf_fifo_rd_rq  out  1  FIFO pop request
- cntl_inbuf_fifo_mem_en  out  1  FIFO memory enable
- cntl_eng_load_line  out  1  engine captures FIFO data this cycle
- cntl_bm_mem_rd_en  out  1  bitmatrix row read
- cntl_bm_mem_rd_addr  out  M_W  bitmatrix row index 0..M-1
- cntl_outbuf_wr_en  out  1  write engine result row
- cntl_outbuf_row_idx  out  M_W  row index of the written result
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle completion pulse
- err_cfg  out  1  one-cycle illegal-configuration pulse

## Operation
- FSM states: IDLE, FETCH, LOAD, CALC, DONE.
- **IDLE**
  - On start, check MReg and line_num_reg. The configuration is legal when M_MIN ≤ MReg ≤ M_MAX and line_num_reg ≠ 0.
  - Legal: latch m_lat=MReg and lines_left=line_num_reg, then go to FETCH.
  - Illegal: pulse err_cfg the next cycle and stay in IDLE.
  - MReg and line_num_reg are ignored outside IDLE.
- **FETCH**
  - cntl_inbuf_fifo_rd_rq = cntl_inbuf_fifo_mem_en = ~inbuf_fifo_cntl_empty.
  - When the request is asserted, go to LOAD. Otherwise stay in FETCH, stalling indefinitely.
- **LOAD**
  - FIFO read latency is 1 cycle. Assert cntl_eng_load_line for exactly this cycle.
  - Clear row_cnt to 0 and go to CALC.
- **CALC**
  - When ~outbuf_full: assert cntl_bm_mem_rd_en with cntl_bm_mem_rd_addr=row_cnt, then increment row_cnt.
  - When outbuf_full: deassert rd_en, hold row_cnt and hold the address.
  - After issuing row m_lat-1, decrement lines_left.
    - If lines_left was 1, go to DONE.
    - Otherwise go to FETCH.
- **DONE**: pulse done for 1 cycle, then go to IDLE.
- Write path: cntl_outbuf_wr_en and cntl_outbuf_row_idx are cntl_bm_mem_rd_en and cntl_bm_mem_rd_addr delayed by 1 register stage, matching the 1-cycle bitmatrix read latency. outbuf_full does not gate this already-issued stage.
- start is ignored while busy.
- Arithmetic:
  - row_cnt compares against m_lat-1 at M_W width; it never exceeds m_lat-1.
  - lines_left is a down-counter and never wraps below 0.

## Timing
- Reset values, applied on rstn low and on eng_rstn low at a clock edge:
  - State = IDLE.
  - All outputs 0, including the write-delay stage.
  - Counters and latches cleared.
- eng_rstn mid-operation:
  - Abort on the next edge.
  - No done pulse.
  - Any pending delayed write is dropped.
- Nominal latency, with start in cycle 0, FIFO never empty and no outbuf_full:
  - FETCH in cycle 1, LOAD in cycle 2, CALC rows in cycles 3..M+2.
  - Each line costs M+2 cycles.
  - For N lines, done is high in cycle N(M+2)+1, the same cycle as the final outbuf write.
- No overlap between lines: the FIFO is never popped during CALC.
- busy rises in cycle 1 and falls after the DONE cycle.

## Test plan
- MReg=4, line_num_reg=1, no stalls, start at cycle 0 ->
  - rd_rq in cycle 1, load_line in cycle 2.
  - bm addr 0,1,2,3 in cycles 3–6.
  - outbuf_wr rows 0–3 in cycles 4–7, done in cycle 7.
- MReg=2, line_num_reg=3, FIFO empty for 5 cycles at the second FETCH -> rd_rq held low while empty. Exactly 3 load_line pulses, 6 outbuf writes (rows 0,1,0,1,0,1), 1 done.
- MReg=4, outbuf_full high for 3 cycles after row 1 is issued -> rd_en low for 3 cycles with addr held at 2. Row 1 is still written. Rows 2 and 3 follow, and no row is duplicated or skipped.
- Illegal configurations, each in turn: MReg=1; MReg=M_MAX+1; line_num_reg=0 -> err_cfg pulse, busy stays 0, no FIFO request.
- eng_rstn low during CALC row 2 of MReg=8 -> next cycle: state IDLE, all outputs 0, no done. A new start then runs cleanly from row 0.
- start re-pulsed while busy, and MReg changed mid-run -> both ignored. The run uses the latched M.
